// File: rtl/bp_fe_dual_queue_pkg.sv
// bp_fe_dual_queue_pkg: shared width/depth constants for the FE-to-BE dual queue
package bp_fe_dual_queue_pkg;
  localparam int fe_queue_width_lp = 32;
  localparam int dual_queue_els_lp = 8;
endpackage

// File: rtl/bp_fe_dual_queue_if.sv
// bp_fe_dual_queue_if: two-wide enqueue and dequeue handshake bundle between FE, queue and BE
interface bp_fe_dual_queue_if
  import bp_fe_dual_queue_pkg::*;
#(
  parameter int width_p = fe_queue_width_lp
);
  logic [width_p-1:0] enq1_data_i;
  logic               enq1_v_i;
  logic [width_p-1:0] enq2_data_i;
  logic               enq2_v_i;
  logic               enq_ready_o;
  logic [width_p-1:0] deq1_data_o;
  logic               deq1_v_o;
  logic [width_p-1:0] deq2_data_o;
  logic               deq2_v_o;
  logic               deq1_yumi_i;
  logic               deq2_yumi_i;
  modport master (
    output enq1_data_i, enq1_v_i, enq2_data_i, enq2_v_i, deq1_yumi_i, deq2_yumi_i,
    input  enq_ready_o, deq1_data_o, deq1_v_o, deq2_data_o, deq2_v_o
  );
  modport slave (
    input  enq1_data_i, enq1_v_i, enq2_data_i, enq2_v_i, deq1_yumi_i, deq2_yumi_i,
    output enq_ready_o, deq1_data_o, deq1_v_o, deq2_data_o, deq2_v_o
  );
endinterface

// File: rtl/bp_fe_dual_queue_ptr.sv
// bp_fe_dual_queue_ptr: wrapping queue pointer advanced by 0, 1 or 2 per cycle
module bp_fe_dual_queue_ptr #(
  parameter int els_p = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     clear_i,
  input  logic [1:0]               inc_i,
  output logic [$clog2(els_p)-1:0] ptr_o,
  output logic [$clog2(els_p)-1:0] ptr_p1_o
);
  localparam int pw = $clog2(els_p);
  logic [pw-1:0] ptr_q, ptr_d;
  assign ptr_d    = clear_i ? '0 : ptr_q + pw'(inc_i);
  assign ptr_o    = ptr_q;
  assign ptr_p1_o = ptr_q + pw'(1);
  // pointer register; power-of-2 depth makes the natural overflow the wrap
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) ptr_q <= '0;
    else            ptr_q <= ptr_d;
endmodule

// File: rtl/bp_fe_dual_queue.sv
// bp_fe_dual_queue: two-in/two-out in-order FIFO between FE fetch and the dual-issue BE
module bp_fe_dual_queue
  import bp_fe_dual_queue_pkg::*;
#(
  parameter int els_p   = dual_queue_els_lp,
  parameter int width_p = fe_queue_width_lp
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   flush_i,
  bp_fe_dual_queue_if.slave      q_if,
  output logic [$clog2(els_p):0] count_o
);
  localparam int pw = $clog2(els_p);
  localparam int cw = pw + 1;
  logic [width_p-1:0] mem_q [els_p];
  logic [cw-1:0]      count_q, count_d;
  logic [pw-1:0]      rptr, rptr_p1, wptr, wptr_p1;
  logic               acc, we1, we2, rd1, rd2;
  logic [1:0]         n_enq, n_deq;
  // ready depends only on registered occupancy so a same-cycle dequeue never opens space
  assign q_if.enq_ready_o = reset_n_i & ((cw'(els_p) - count_q) >= cw'(2));
  assign acc   = q_if.enq_ready_o & ~flush_i;
  assign we1   = acc & (q_if.enq1_v_i | q_if.enq2_v_i);
  assign we2   = acc & q_if.enq1_v_i & q_if.enq2_v_i;
  assign n_enq = we2 ? 2'd2 : we1 ? 2'd1 : 2'd0;
  // retirement is strictly in order: deq2 only counts alongside deq1
  assign rd1   = ~flush_i & q_if.deq1_yumi_i & q_if.deq1_v_o;
  assign rd2   = rd1 & q_if.deq2_yumi_i & q_if.deq2_v_o;
  assign n_deq = rd2 ? 2'd2 : rd1 ? 2'd1 : 2'd0;
  assign count_d = flush_i ? '0 : count_q + cw'(n_enq) - cw'(n_deq);
  assign count_o = count_q;
  assign q_if.deq1_v_o    = count_q >= cw'(1);
  assign q_if.deq2_v_o    = count_q >= cw'(2);
  assign q_if.deq1_data_o = mem_q[rptr];
  assign q_if.deq2_data_o = mem_q[rptr_p1];
  bp_fe_dual_queue_ptr #(.els_p(els_p)) u_wptr (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .clear_i(flush_i),
    .inc_i(n_enq), .ptr_o(wptr), .ptr_p1_o(wptr_p1)
  );
  bp_fe_dual_queue_ptr #(.els_p(els_p)) u_rptr (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .clear_i(flush_i),
    .inc_i(n_deq), .ptr_o(rptr), .ptr_p1_o(rptr_p1)
  );
  // occupancy register
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) count_q <= '0;
    else            count_q <= count_d;
  // storage; a lone enq2 is compacted into the wptr slot
  always_ff @(posedge clk_i) begin
    if (we1) mem_q[wptr]    <= q_if.enq1_v_i ? q_if.enq1_data_i : q_if.enq2_data_i;
    if (we2) mem_q[wptr_p1] <= q_if.enq2_data_i;
  end
endmodule

// File: tb/tb_bp_fe_dual_queue.sv
// tb_bp_fe_dual_queue: scoreboard-driven checks of the dual FE queue
module tb_bp_fe_dual_queue;
  import bp_fe_dual_queue_pkg::*;
  localparam int W = fe_queue_width_lp;
  localparam int N = 8;
  logic clk = 1'b0, reset_n = 1'b0, flush = 1'b0;
  logic [3:0] count;
  logic [W-1:0] exp_q[$];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  bp_fe_dual_queue_if #(.width_p(W)) q_if();
  bp_fe_dual_queue #(.els_p(N), .width_p(W)) u_dut (
    .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush), .q_if(q_if), .count_o(count)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic drive(input logic v1, input logic [W-1:0] d1, input logic v2, input logic [W-1:0] d2,
                       input logic y1, input logic y2, input logic fl);
    logic rdy;
    int sz;
    q_if.enq1_v_i = v1; q_if.enq1_data_i = d1;
    q_if.enq2_v_i = v2; q_if.enq2_data_i = d2;
    q_if.deq1_yumi_i = y1; q_if.deq2_yumi_i = y2;
    flush = fl;
    sz  = exp_q.size();
    rdy = (N - sz) >= 2;
    if (v1 || v2) begin
      tests++;
      if (q_if.enq_ready_o !== 1'b1) begin
        fails++;
        $display("FAIL protocol: enqueue with enq_ready_o=%b required 1", q_if.enq_ready_o);
      end
    end
    if (fl) exp_q.delete();
    else begin
      if (y1 && sz >= 1) void'(exp_q.pop_front());
      if (y1 && y2 && sz >= 2) void'(exp_q.pop_front());
      if (rdy && v1) exp_q.push_back(d1);
      if (rdy && v2) exp_q.push_back(d2);
    end
    @(posedge clk); #1;
    q_if.enq1_v_i = 1'b0; q_if.enq2_v_i = 1'b0;
    q_if.deq1_yumi_i = 1'b0; q_if.deq2_yumi_i = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    @(posedge clk); #1;
    tests++; if (q_if.enq_ready_o !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", q_if.enq_ready_o); end
    tests++; if (q_if.deq1_v_o !== 1'b0) begin fails++; $display("FAIL rst_v1: got %b want 0", q_if.deq1_v_o); end
    tests++; if (q_if.deq2_v_o !== 1'b0) begin fails++; $display("FAIL rst_v2: got %b want 0", q_if.deq2_v_o); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (q_if.enq_ready_o !== 1'b1) begin fails++; $display("FAIL idle_ready: got %b want 1", q_if.enq_ready_o); end
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL idle_count: got %0d want 0", count); end
    tests++; if (q_if.deq1_v_o !== 1'b0 || q_if.deq2_v_o !== 1'b0) begin fails++; $display("FAIL idle_v: got %b%b want 00", q_if.deq1_v_o, q_if.deq2_v_o); end
  endtask

  task automatic test_dual;
    drive(1'b1, 32'hA000_000A, 1'b1, 32'hB000_000B, 1'b0, 1'b0, 1'b0);
    tests++; if (q_if.deq1_v_o !== 1'b1 || q_if.deq1_data_o !== exp_q[0]) begin fails++; $display("FAIL dual_deq1: got v=%b %h want 1 %h", q_if.deq1_v_o, q_if.deq1_data_o, exp_q[0]); end
    tests++; if (q_if.deq2_v_o !== 1'b1 || q_if.deq2_data_o !== 32'hB000_000B) begin fails++; $display("FAIL dual_deq2: got v=%b %h want 1 b000000b", q_if.deq2_v_o, q_if.deq2_data_o); end
    tests++; if (count !== 4'd2) begin fails++; $display("FAIL dual_count: got %0d want 2", count); end
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    tests++; if (count !== 4'd0 || q_if.deq1_v_o !== 1'b0 || q_if.deq2_v_o !== 1'b0) begin fails++; $display("FAIL dual_drain: got count=%0d v=%b%b want 0 00", count, q_if.deq1_v_o, q_if.deq2_v_o); end
  endtask

  task automatic test_lone_enq2;
    drive(1'b0, '0, 1'b1, 32'hC000_000C, 1'b0, 1'b0, 1'b0);
    tests++; if (q_if.deq1_v_o !== 1'b1 || q_if.deq1_data_o !== 32'hC000_000C) begin fails++; $display("FAIL lone_deq1: got v=%b %h want 1 c000000c", q_if.deq1_v_o, q_if.deq1_data_o); end
    tests++; if (q_if.deq2_v_o !== 1'b0 || count !== 4'd1) begin fails++; $display("FAIL lone_state: got v2=%b count=%0d want 0 1", q_if.deq2_v_o, count); end
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL lone_yumi2_invalid: got count=%0d want 0", count); end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 4; i++) begin
      tests++; if (q_if.enq_ready_o !== 1'b1) begin fails++; $display("FAIL fill_ready%0d: got %b want 1", i, q_if.enq_ready_o); end
      drive(1'b1, W'(32'h1000 + 2 * i), 1'b1, W'(32'h1001 + 2 * i), 1'b0, 1'b0, 1'b0);
    end
    tests++; if (count !== 4'd8 || q_if.enq_ready_o !== 1'b0) begin fails++; $display("FAIL full: got count=%0d ready=%b want 8 0", count, q_if.enq_ready_o); end
    tests++; if (q_if.deq1_data_o !== exp_q[0]) begin fails++; $display("FAIL full_deq1: got %h want %h", q_if.deq1_data_o, exp_q[0]); end
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    tests++; if (count !== 4'd7 || q_if.enq_ready_o !== 1'b0) begin fails++; $display("FAIL seven: got count=%0d ready=%b want 7 0", count, q_if.enq_ready_o); end
    tests++; if (q_if.deq1_data_o !== exp_q[0]) begin fails++; $display("FAIL seven_deq1: got %h want %h", q_if.deq1_data_o, exp_q[0]); end
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    tests++; if (count !== 4'd6 || q_if.enq_ready_o !== 1'b1) begin fails++; $display("FAIL six: got count=%0d ready=%b want 6 1", count, q_if.enq_ready_o); end
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    tests++; if (count !== 4'd6) begin fails++; $display("FAIL yumi2_alone: got count=%0d want 6", count); end
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
      tests++; if (q_if.deq1_data_o !== exp_q[0]) begin fails++; $display("FAIL drain_deq1: got %h want %h", q_if.deq1_data_o, exp_q[0]); end
      if (exp_q.size() >= 2) begin
        tests++; if (q_if.deq2_data_o !== exp_q[1]) begin fails++; $display("FAIL drain_deq2: got %h want %h", q_if.deq2_data_o, exp_q[1]); end
      end
      drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    end
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL drained: got count=%0d want 0", count); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 4; i++) drive(1'b1, W'(32'h2000 + i), 1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    tests++; if (u_dut.u_wptr.ptr_q !== 3'd7 || u_dut.u_rptr.ptr_q !== 3'd7) begin fails++; $display("FAIL wrap_pre: got w=%0d r=%0d want 7 7", u_dut.u_wptr.ptr_q, u_dut.u_rptr.ptr_q); end
    drive(1'b1, 32'hD000_000D, 1'b1, 32'hE000_000E, 1'b0, 1'b0, 1'b0);
    tests++; if (q_if.deq1_data_o !== 32'hD000_000D || q_if.deq2_data_o !== 32'hE000_000E) begin fails++; $display("FAIL wrap_data: got %h %h want d000000d e000000e", q_if.deq1_data_o, q_if.deq2_data_o); end
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    tests++; if (u_dut.u_wptr.ptr_q !== 3'd1 || u_dut.u_rptr.ptr_q !== 3'd1 || count !== 4'd0) begin fails++; $display("FAIL wrap_post: got w=%0d r=%0d count=%0d want 1 1 0", u_dut.u_wptr.ptr_q, u_dut.u_rptr.ptr_q, count); end
  endtask

  task automatic test_flush;
    drive(1'b1, 32'h3000, 1'b1, 32'h3001, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h3002, 1'b1, 32'h3003, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h3004, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    tests++; if (count !== 4'd5) begin fails++; $display("FAIL flush_pre: got count=%0d want 5", count); end
    drive(1'b1, 32'h5A5A_5A5A, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    tests++; if (count !== 4'd0 || q_if.deq1_v_o !== 1'b0 || q_if.deq2_v_o !== 1'b0 || q_if.enq_ready_o !== 1'b1) begin fails++; $display("FAIL flush_post: got count=%0d v=%b%b ready=%b want 0 00 1", count, q_if.deq1_v_o, q_if.deq2_v_o, q_if.enq_ready_o); end
    drive(1'b1, 32'h4000_0004, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    tests++; if (q_if.deq1_data_o !== 32'h4000_0004 || q_if.deq2_v_o !== 1'b0 || count !== 4'd1) begin fails++; $display("FAIL flush_after: got %h v2=%b count=%0d want 40000004 0 1", q_if.deq1_data_o, q_if.deq2_v_o, count); end
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic rdy, v1, v2;
    for (int i = 0; i < 80; i++) begin
      rdy = (N - exp_q.size()) >= 2;
      tests++; if (count !== 4'(exp_q.size()) || q_if.enq_ready_o !== rdy) begin fails++; $display("FAIL b2b_state%0d: got count=%0d ready=%b want %0d %b", i, count, q_if.enq_ready_o, exp_q.size(), rdy); end
      if (exp_q.size() >= 1) begin
        tests++; if (q_if.deq1_v_o !== 1'b1 || q_if.deq1_data_o !== exp_q[0]) begin fails++; $display("FAIL b2b_deq1_%0d: got v=%b %h want 1 %h", i, q_if.deq1_v_o, q_if.deq1_data_o, exp_q[0]); end
      end
      if (exp_q.size() >= 2) begin
        tests++; if (q_if.deq2_v_o !== 1'b1 || q_if.deq2_data_o !== exp_q[1]) begin fails++; $display("FAIL b2b_deq2_%0d: got v=%b %h want 1 %h", i, q_if.deq2_v_o, q_if.deq2_data_o, exp_q[1]); end
      end
      v1 = rdy & 1'($urandom_range(1));
      v2 = rdy & 1'($urandom_range(1));
      drive(v1, W'($urandom), v2, W'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)), ($urandom_range(15) == 0));
    end
  endtask

  task automatic test_async_reset;
    drive(1'b1, 32'h6000, 1'b1, 32'h6001, 1'b0, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    exp_q.delete();
    tests++; if (count !== 4'd0 || q_if.deq1_v_o !== 1'b0 || q_if.enq_ready_o !== 1'b0) begin fails++; $display("FAIL async_rst: got count=%0d v1=%b ready=%b want 0 0 0", count, q_if.deq1_v_o, q_if.enq_ready_o); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (q_if.enq_ready_o !== 1'b1 || count !== 4'd0) begin fails++; $display("FAIL async_release: got ready=%b count=%0d want 1 0", q_if.enq_ready_o, count); end
  endtask

  initial begin
    q_if.enq1_v_i = 1'b0; q_if.enq2_v_i = 1'b0;
    q_if.enq1_data_i = '0; q_if.enq2_data_i = '0;
    q_if.deq1_yumi_i = 1'b0; q_if.deq2_yumi_i = 1'b0;
    test_reset();
    test_dual();
    test_lone_enq2();
    test_fill();
    test_wrap();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
